frame_rx_ctrl: RTL and testbench

Sequencing controller for the serial preamble catcher (pre_catch). It holds the catcher cleared when disabled and arms it to hunt for a preamble. Once pre fires, it deserialises a fixed-length payload from the same serial data line at a fixed clocks-per-bit rate. It hands each payload word to a downstream consumer over a valid/ready handshake, then re-arms the catcher for the next frame.

---
 rtl/frame_pkg.sv | 15 +
 rtl/bit_sampler.sv | 59 +++++
 rtl/frame_rx_ctrl.sv | 147 ++++++++++++++
 tb/tb_frame_rx_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared state encoding and default parameters for the frame receive controller.
package frame_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_HUNT = 2'b01,
        ST_RECV = 2'b10,
        ST_HOLD = 2'b11
    } state_e;

    localparam int unsigned DEF_PAYLOAD_BITS = 8;
    localparam int unsigned DEF_BIT_DIV      = 4;
    localparam int unsigned DEF_HUNT_TIMEOUT = 64;

endpackage

// File: rtl/bit_sampler.sv
// Mid-bit serial sampler: divides the clock to bit rate, shifts data in MSB first,
// and flags done once a full payload word has been captured.
module bit_sampler #(
    parameter int unsigned PAYLOAD_BITS = 8,
    parameter int unsigned BIT_DIV      = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clear_i,
    input  logic                    enable_i,
    input  logic                    data_i,
    output logic                    done_o,
    output logic [PAYLOAD_BITS-1:0] word_o
);

    localparam int unsigned DivW = $clog2(BIT_DIV);
    localparam int unsigned CntW = $clog2(PAYLOAD_BITS + 1);
    localparam logic [DivW-1:0] DivLast = DivW'(BIT_DIV - 1);
    localparam logic [DivW-1:0] DivMid  = DivW'(BIT_DIV / 2 - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(PAYLOAD_BITS);

    logic [DivW-1:0]         div_q, div_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [PAYLOAD_BITS-1:0] shift_q, shift_d;

    assign done_o = (cnt_q == CntFull);
    assign word_o = shift_q;

    always_comb begin
        div_d   = div_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clear_i) begin
            div_d   = '0;
            cnt_d   = '0;
            shift_d = '0;
        end else if (enable_i) begin
            div_d = (div_q == DivLast) ? '0 : div_q + DivW'(1);
            // Stop shifting once full so the word stays intact until the FSM takes it.
            if (div_q == DivMid && !done_o) begin
                shift_d = (shift_q << 1) | PAYLOAD_BITS'(data_i);
                cnt_d   = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q   <= '0;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

endmodule

// File: rtl/frame_rx_ctrl.sv
// Sequencer for the preamble catcher: arms it, receives a fixed-length payload after a
// preamble, and presents the word over valid/ready before re-arming.
module frame_rx_ctrl
    import frame_pkg::*;
#(
    parameter int unsigned PAYLOAD_BITS = DEF_PAYLOAD_BITS,
    parameter int unsigned BIT_DIV      = DEF_BIT_DIV,
    parameter int unsigned HUNT_TIMEOUT = DEF_HUNT_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    data,
    input  logic                    pre,
    output logic                    catch_clr,
    output logic [PAYLOAD_BITS-1:0] data_out,
    output logic                    valid,
    input  logic                    ready,
    output logic [1:0]              state,
    output logic                    timeout,
    output logic                    overrun
);

    localparam logic [15:0] HuntLast = 16'(HUNT_TIMEOUT - 1);

    state_e                  state_q, state_d;
    logic [15:0]             hunt_q, hunt_d;
    logic                    catch_clr_q, catch_clr_d;
    logic [PAYLOAD_BITS-1:0] data_out_q, data_out_d;
    logic                    valid_q, valid_d;
    logic                    timeout_q, timeout_d;
    logic                    overrun_q, overrun_d;

    logic                    smp_clear, smp_enable, smp_done;
    logic [PAYLOAD_BITS-1:0] smp_word;

    // Sampler is held cleared outside RECV, so it always starts a frame from zero.
    assign smp_clear  = (state_q != ST_RECV);
    assign smp_enable = (state_q == ST_RECV);

    bit_sampler #(
        .PAYLOAD_BITS(PAYLOAD_BITS),
        .BIT_DIV     (BIT_DIV)
    ) u_bit_sampler (
        .clk_i   (clk),
        .rst_i   (rst),
        .clear_i (smp_clear),
        .enable_i(smp_enable),
        .data_i  (data),
        .done_o  (smp_done),
        .word_o  (smp_word)
    );

    always_comb begin
        state_d     = state_q;
        hunt_d      = hunt_q;
        catch_clr_d = catch_clr_q;
        data_out_d  = data_out_q;
        valid_d     = valid_q;
        timeout_d   = 1'b0;
        overrun_d   = overrun_q;
        case (state_q)
            ST_IDLE: begin
                catch_clr_d = 1'b1;
                if (en) begin
                    state_d     = ST_HUNT;
                    hunt_d      = '0;
                    catch_clr_d = 1'b0;
                end
            end
            ST_HUNT: begin
                catch_clr_d = 1'b0;
                if (!en) begin
                    state_d     = ST_IDLE;
                    catch_clr_d = 1'b1;
                end else if (pre) begin
                    state_d = ST_RECV;
                end else if (hunt_q == HuntLast) begin
                    timeout_d   = 1'b1;
                    catch_clr_d = 1'b1;
                    hunt_d      = '0;
                end else begin
                    hunt_d = hunt_q + 16'd1;
                end
            end
            ST_RECV: begin
                catch_clr_d = 1'b0;
                if (!en) begin
                    state_d     = ST_IDLE;
                    catch_clr_d = 1'b1;
                end else if (smp_done) begin
                    state_d     = ST_HOLD;
                    data_out_d  = smp_word;
                    valid_d     = 1'b1;
                    catch_clr_d = 1'b1;
                end
            end
            ST_HOLD: begin
                catch_clr_d = 1'b0;
                if (pre) begin
                    overrun_d = 1'b1;
                end
                if (valid_q && ready) begin
                    valid_d     = 1'b0;
                    hunt_d      = '0;
                    state_d     = en ? ST_HUNT : ST_IDLE;
                    catch_clr_d = !en;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                catch_clr_d = 1'b1;
            end
        endcase
        if (state_d == ST_IDLE) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hunt_q      <= '0;
            catch_clr_q <= 1'b1;
            data_out_q  <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hunt_q      <= hunt_d;
            catch_clr_q <= catch_clr_d;
            data_out_q  <= data_out_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            overrun_q   <= overrun_d;
        end
    end

    assign state     = state_q;
    assign catch_clr = catch_clr_q;
    assign data_out  = data_out_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_frame_rx_ctrl.sv
// Self-checking bench for frame_rx_ctrl: table frames, hand corner sequences and
// randomized frames checked against a bit-list model of the serial payload.
module tb_frame_rx_ctrl;

    localparam int unsigned P   = 8;
    localparam int unsigned DIV = 4;
    localparam int unsigned TMO = 64;
    // Last mid-bit sample lands DIV/2 + DIV*(P-1) edges after pre; valid one edge later.
    localparam int VALID_AT = DIV / 2 + DIV * (P - 1) + 1;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_HUNT = 2'b01;
    localparam logic [1:0] S_RECV = 2'b10;
    localparam logic [1:0] S_HOLD = 2'b11;

    logic         clk;
    logic         rst;
    logic         en;
    logic         data;
    logic         pre;
    logic         catch_clr;
    logic [P-1:0] data_out;
    logic         valid;
    logic         ready;
    logic [1:0]   state;
    logic         timeout;
    logic         overrun;

    int n_chk;
    int n_err;
    logic         exp_ovr;
    logic [P-1:0] last_word;

    frame_rx_ctrl #(
        .PAYLOAD_BITS(P),
        .BIT_DIV     (DIV),
        .HUNT_TIMEOUT(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data     (data),
        .pre      (pre),
        .catch_clr(catch_clr),
        .data_out (data_out),
        .valid    (valid),
        .ready    (ready),
        .state    (state),
        .timeout  (timeout),
        .overrun  (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the word is simply the serial bits in send order, first bit in MSB.
    function automatic logic [P-1:0] model_word(input logic [P-1:0] seq);
        logic [P-1:0] w;
        w = '0;
        for (int i = 0; i < int'(P); i++) w = (w << 1) | P'(seq[i]);
        return w;
    endfunction

    // Sends one frame (seq[i] is the i-th serial bit) starting in HUNT, then holds for
    // dly cycles (optionally pulsing pre) and accepts with en=accept_en.
    task automatic run_frame(input logic [P-1:0] seq, input logic [P-1:0] exp_w, input int dly,
                             input bit pre_hold, input bit accept_en, input string tag);
        int first_v;
        int bad_hold;
        first_v = -1;
        pre = 1'b1;
        tick();
        pre = 1'b0;
        chk({tag, "_recv_state"}, 64'(state), 64'(S_RECV));
        data = seq[0];
        for (int c = 1; c <= VALID_AT + 4 && first_v < 0; c++) begin
            tick();
            if (valid === 1'b1) first_v = c;
            if (c % DIV == 0 && c / DIV < int'(P)) data = seq[c / DIV];
        end
        chk({tag, "_latency"}, 64'(first_v), 64'(VALID_AT));
        chk({tag, "_word"}, 64'(data_out), 64'(exp_w));
        chk({tag, "_hold_clr"}, 64'(catch_clr), 64'd1);
        chk({tag, "_hold_state"}, 64'(state), 64'(S_HOLD));
        bad_hold = 0;
        en = accept_en;
        for (int d = 0; d < dly; d++) begin
            pre = pre_hold && d == 0;
            tick();
            pre = 1'b0;
            if (valid !== 1'b1 || data_out !== exp_w || state !== S_HOLD) bad_hold++;
            if (catch_clr !== 1'b0) bad_hold++;
            if (pre_hold && overrun !== 1'b1) bad_hold++;
        end
        if (pre_hold) exp_ovr = 1'b1;
        chk({tag, "_hold_stable"}, 64'(bad_hold), 64'd0);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        if (!accept_en) exp_ovr = 1'b0;
        chk({tag, "_acc_valid"}, 64'(valid), 64'd0);
        chk({tag, "_acc_state"}, 64'(state), accept_en ? 64'(S_HUNT) : 64'(S_IDLE));
        chk({tag, "_acc_clr"}, 64'(catch_clr), accept_en ? 64'd0 : 64'd1);
        chk({tag, "_overrun"}, 64'(overrun), 64'(exp_ovr));
        chk({tag, "_acc_word"}, 64'(data_out), 64'(exp_w));
        last_word = exp_w;
        if (!accept_en) begin
            en = 1'b1;
            tick();
        end
    endtask

    typedef struct {
        logic [P-1:0] seq;
        int           dly;
        logic [P-1:0] exp_word;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int   tmo_bad;
        int   pulses;
        int   vseen;
        logic [P-1:0] seq;
        int   dly;
        bit   ph;
        bit   acc;

        vecs[0] = '{seq: 8'h65, dly: 0,  exp_word: 8'hA6};
        vecs[1] = '{seq: 8'h65, dly: 10, exp_word: 8'hA6};
        vecs[2] = '{seq: 8'h00, dly: 2,  exp_word: 8'h00};
        vecs[3] = '{seq: 8'hFF, dly: 1,  exp_word: 8'hFF};
        vecs[4] = '{seq: 8'h01, dly: 0,  exp_word: 8'h80};
        vecs[5] = '{seq: 8'h0F, dly: 3,  exp_word: 8'hF0};
        vecs[6] = '{seq: 8'h80, dly: 1,  exp_word: 8'h01};

        n_chk = 0;
        n_err = 0;
        exp_ovr = 1'b0;
        last_word = '0;
        rst = 1'b1;
        en = 1'b0;
        data = 1'b0;
        pre = 1'b0;
        ready = 1'b0;

        repeat (3) tick();
        rst = 1'b0;
        repeat (20) tick();
        chk("idle_state", 64'(state), 64'(S_IDLE));
        chk("idle_clr", 64'(catch_clr), 64'd1);
        chk("idle_valid", 64'(valid), 64'd0);
        chk("idle_data", 64'(data_out), 64'd0);
        chk("idle_timeout", 64'(timeout), 64'd0);
        chk("idle_overrun", 64'(overrun), 64'd0);

        en = 1'b1;
        tick();
        chk("arm_state", 64'(state), 64'(S_HUNT));
        chk("arm_clr", 64'(catch_clr), 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_frame(vecs[i].seq, vecs[i].exp_word, vecs[i].dly, 1'b0, 1'b1, $sformatf("vec%0d", i));
        end

        // Overrun while pending, then accept with en low.
        run_frame(8'h3C, model_word(8'h3C), 4, 1'b1, 1'b0, "ovr");

        for (int i = 0; i < 25; i++) begin
            seq = P'($urandom);
            ph  = ($urandom_range(0, 3) == 0);
            dly = ph ? int'($urandom_range(1, 4)) : int'($urandom_range(0, 4));
            acc = ($urandom_range(0, 4) != 0);
            run_frame(seq, model_word(seq), dly, ph, acc, $sformatf("rnd%0d", i));
            repeat ($urandom_range(0, 3)) tick();
        end

        en = 1'b0;
        tick();
        chk("rnd_end_state", 64'(state), 64'(S_IDLE));
        chk("rnd_end_overrun", 64'(overrun), 64'd0);

        // Hunt timeout: pulses exactly TMO and 2*TMO edges after entering HUNT.
        en = 1'b1;
        tick();
        tmo_bad = 0;
        pulses = 0;
        for (int c = 1; c <= 130; c++) begin
            tick();
            if (timeout === 1'b1) pulses++;
            if (timeout !== (c == TMO || c == 2 * TMO)) tmo_bad++;
            if (catch_clr !== (c == TMO || c == 2 * TMO)) tmo_bad++;
            if (state !== S_HUNT) tmo_bad++;
        end
        chk("tmo_pattern", 64'(tmo_bad), 64'd0);
        chk("tmo_count", 64'(pulses), 64'd2);

        // Abort during bit 3 of RECV.
        pre = 1'b1;
        tick();
        pre = 1'b0;
        data = 1'b1;
        repeat (3 * DIV) tick();
        chk("abort_pre_state", 64'(state), 64'(S_RECV));
        en = 1'b0;
        tick();
        chk("abort_state", 64'(state), 64'(S_IDLE));
        chk("abort_clr", 64'(catch_clr), 64'd1);
        vseen = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (valid !== 1'b0) vseen++;
        end
        chk("abort_no_valid", 64'(vseen), 64'd0);
        chk("abort_word", 64'(data_out), 64'(last_word));

        // Asynchronous reset mid-RECV, checked between clock edges.
        en = 1'b1;
        tick();
        pre = 1'b1;
        tick();
        pre = 1'b0;
        repeat (10) tick();
        chk("ar_pre_state", 64'(state), 64'(S_RECV));
        #2;
        rst = 1'b1;
        #1;
        chk("ar_state", 64'(state), 64'(S_IDLE));
        chk("ar_clr", 64'(catch_clr), 64'd1);
        chk("ar_valid", 64'(valid), 64'd0);
        chk("ar_data", 64'(data_out), 64'd0);
        chk("ar_overrun", 64'(overrun), 64'd0);
        rst = 1'b0;
        en = 1'b0;
        repeat (3) tick();
        chk("ar_after_state", 64'(state), 64'(S_IDLE));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
